fma16_vecseq: RTL and testbench

FMA16_VECSEQ -- requirements
Module: fma16_vecseq

---
 rtl/fma16_vecseq.sv | 215 +++++++++++++++++++++
 tb/tb_fma16_vecseq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_vecseq.sv
// fma16_vecseq -- test-vector sequencer for a combinational fma16 unit.
//
// Reads 76-bit vectors from a synchronous vector memory. Each vector's
// operands and controls are applied to the fma16 through registers. The
// fma16 result is then compared with the expected value stored in the
// vector. The sequencer counts the vectors it has checked and the
// mismatches it has found.
//
// Vector layout: {x[75:60], y[59:44], z[43:28], ctrl[27:20], rexp[19:4], fexp[3:0]}
//   ctrl[5:0] = {roundmode[1:0], mul, add, negp, negz}; ctrl[7:6] are ignored.
//
// Parameters:
//   ADDR_W      vector-memory address width
//   MAX_ERRORS  stop the run after this many mismatches (0 = never stop early)
//
// Ports:
//   clk, reset_n          clock (rising edge); asynchronous active-low reset
//   start                 one-cycle request to begin a run (used in IDLE/DONE)
//   vec_addr              vector-memory read address
//   vec_data, vec_valid   vector for the previous cycle's address; valid=0 ends the run
//   x, y, z               registered operands to the fma16
//   mul, add, negp, negz  registered controls to the fma16
//   roundmode             registered rounding mode to the fma16
//   result, flags         fma16 outputs; flags = {invalid, overflow, underflow, inexact}
//   busy, done            run in progress / run finished
//   vectornum, errors     saturating counts of checked vectors and of mismatches
//   err_pulse             one-cycle strobe after each mismatching check
//   first_err             address of the first mismatching vector
//
// Configuration macro:
//   FMA16_FLAG_CHECK_EN   when defined, flags are compared with fexp as well;
//                         when undefined, only the result is compared.

module fma16_vecseq #(
  parameter int ADDR_W     = 20,
  parameter int MAX_ERRORS = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [75:0]       vec_data,
  input  logic              vec_valid,
  output logic [15:0]       x,
  output logic [15:0]       y,
  output logic [15:0]       z,
  output logic              mul,
  output logic              add,
  output logic              negp,
  output logic              negz,
  output logic [1:0]        roundmode,
  input  logic [15:0]       result,
  input  logic [3:0]        flags,
  output logic              busy,
  output logic              done,
  output logic [31:0]       vectornum,
  output logic [31:0]       errors,
  output logic              err_pulse,
  output logic [ADDR_W-1:0] first_err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
    CHECK,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [31:0]       ERR_LIMIT = 32'(MAX_ERRORS);

  state_t      state;
  state_t      state_next;

  logic [15:0] rexp;
  logic [3:0]  fexp;
  logic        mismatch;
  logic [31:0] errors_upd;
  logic [31:0] vectornum_inc;
  logic        run_end;
  logic        unused_bits;

  // The result (and the flags, when flag checking is built in) is compared
  // with the expectation that was latched alongside the operands.
  always_comb begin
    mismatch = (result != rexp);
`ifdef FMA16_FLAG_CHECK_EN
    mismatch = mismatch || (flags != fexp);
`endif
  end

`ifdef FMA16_FLAG_CHECK_EN
  assign unused_bits = ^vec_data[27:26];
`else
  // flags and fexp play no part in the comparison in this build.
  assign unused_bits = ^{vec_data[27:26], flags, fexp};
`endif

  // Saturating counter updates for the CHECK cycle. The early stop looks at
  // the updated error count, so a run ends on the mismatch that reaches the
  // limit.
  always_comb begin
    errors_upd    = errors;
    vectornum_inc = vectornum;
    if (mismatch && (errors != 32'hFFFF_FFFF)) begin
      errors_upd = errors + 32'd1;
    end
    if (vectornum != 32'hFFFF_FFFF) begin
      vectornum_inc = vectornum + 32'd1;
    end
    run_end = (vec_addr == LAST_ADDR) ||
              ((MAX_ERRORS != 0) && (errors_upd == ERR_LIMIT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Each vector takes exactly three cycles: FETCH presents the address,
  // APPLY captures the memory word, and CHECK samples the fma16 output.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        state_next = APPLY;
      end
      APPLY: begin
        busy       = 1'b1;
        state_next = vec_valid ? CHECK : DONE;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = run_end ? DONE : FETCH;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers. The operands and controls keep their last values
  // through DONE and across a restart. A reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_addr  <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      roundmode <= '0;
      mul       <= 1'b0;
      add       <= 1'b0;
      negp      <= 1'b0;
      negz      <= 1'b0;
      rexp      <= '0;
      fexp      <= '0;
      vectornum <= '0;
      errors    <= '0;
      first_err <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_addr  <= '0;
            vectornum <= '0;
            errors    <= '0;
            first_err <= '0;
          end
        end
        APPLY: begin
          if (vec_valid) begin
            x         <= vec_data[75:60];
            y         <= vec_data[59:44];
            z         <= vec_data[43:28];
            roundmode <= vec_data[25:24];
            mul       <= vec_data[23];
            add       <= vec_data[22];
            negp      <= vec_data[21];
            negz      <= vec_data[20];
            rexp      <= vec_data[19:4];
            fexp      <= vec_data[3:0];
          end
        end
        CHECK: begin
          vectornum <= vectornum_inc;
          errors    <= errors_upd;
          err_pulse <= mismatch;
          if (mismatch && (errors == '0)) begin
            first_err <= vec_addr;
          end
          // The address stays on the last vector when the run ends.
          if (!run_end) begin
            vec_addr <= vec_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fma16_vecseq.sv
// Self-checking bench for fma16_vecseq.
//
// Two instances are used. Instance A has the default parameters. Instance B
// has ADDR_W=2 and MAX_ERRORS=2.
//
// A small fake fma16 drives result and flags. It returns correct values for a
// few known cases and a hash of its inputs otherwise.
//
// A transaction-level model expands each run into the sequence of output
// snapshots that the rules require, one snapshot per cycle. A compare process
// checks every snapshot. Literal checks pin the key end-of-run values.

module tb_fma16_vecseq;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pulse;
    logic [19:0] addr;
    logic [31:0] vnum;
    logic [31:0] errs;
    logic [19:0] ferr;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [5:0]  ctl;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance A (defaults) ----------------
  logic        reset_a, start_a;
  logic [19:0] vaddr_a, ferr_a;
  logic [75:0] rd_a;
  logic        rv_a;
  logic [15:0] x_a, y_a, z_a, result_a;
  logic        mul_a, add_a, negp_a, negz_a, busy_a, done_a, err_pulse_a;
  logic [1:0]  rm_a;
  logic [3:0]  flags_a;
  logic [31:0] vectornum_a, errors_a;

  fma16_vecseq dut_a (
    .clk(clk), .reset_n(reset_a), .start(start_a), .vec_addr(vaddr_a),
    .vec_data(rd_a), .vec_valid(rv_a), .x(x_a), .y(y_a), .z(z_a),
    .mul(mul_a), .add(add_a), .negp(negp_a), .negz(negz_a), .roundmode(rm_a),
    .result(result_a), .flags(flags_a), .busy(busy_a), .done(done_a),
    .vectornum(vectornum_a), .errors(errors_a), .err_pulse(err_pulse_a),
    .first_err(ferr_a)
  );

  // ---------------- instance B (ADDR_W=2, MAX_ERRORS=2) ----------------
  logic        reset_b, start_b;
  logic [1:0]  vaddr_b, ferr_b;
  logic [75:0] rd_b;
  logic        rv_b;
  logic [15:0] x_b, y_b, z_b, result_b;
  logic        mul_b, add_b, negp_b, negz_b, busy_b, done_b, err_pulse_b;
  logic [1:0]  rm_b;
  logic [3:0]  flags_b;
  logic [31:0] vectornum_b, errors_b;

  fma16_vecseq #(.ADDR_W(2), .MAX_ERRORS(2)) dut_b (
    .clk(clk), .reset_n(reset_b), .start(start_b), .vec_addr(vaddr_b),
    .vec_data(rd_b), .vec_valid(rv_b), .x(x_b), .y(y_b), .z(z_b),
    .mul(mul_b), .add(add_b), .negp(negp_b), .negz(negz_b), .roundmode(rm_b),
    .result(result_b), .flags(flags_b), .busy(busy_b), .done(done_b),
    .vectornum(vectornum_b), .errors(errors_b), .err_pulse(err_pulse_b),
    .first_err(ferr_b)
  );

  // Vector memories: one per instance, with one cycle of read latency.
  logic [75:0] mem [2][16];
  bit          vld [2][16];

  always @(posedge clk) begin
    rd_a <= mem[0][vaddr_a[3:0]];
    rv_a <= (vaddr_a < 20'd16) && vld[0][vaddr_a[3:0]];
    rd_b <= mem[1][{2'b00, vaddr_b}];
    rv_b <= vld[1][{2'b00, vaddr_b}];
  end

  // Fake fma16: returns {flags, result}.
  function automatic logic [19:0] fake_fma(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [5:0] ctl);
    if (ctl == 6'h08 && c == 16'h0000) begin
      if (a == 16'h3C00 && b == 16'h3C00) return {4'h0, 16'h3C00};
      if (a == 16'h3C00 && b == 16'h4000) return {4'h0, 16'h4000};
      if (a == 16'h4000 && b == 16'h4000) return {4'h0, 16'h4400};
      if (a == 16'h3C01 && b == 16'h3C01) return {4'h1, 16'h3C02};
    end
    if (ctl == 6'h0C && a == 16'h3C00 && b == 16'h3C00 && c == 16'h3C00)
      return {4'h0, 16'h4000};
    return {4'h0, a ^ b ^ c ^ {10'b0, ctl}};
  endfunction

  assign {flags_a, result_a} = fake_fma(x_a, y_a, z_a, {rm_a, mul_a, add_a, negp_a, negz_a});
  assign {flags_b, result_b} = fake_fma(x_b, y_b, z_b, {rm_b, mul_b, add_b, negp_b, negz_b});

  // ---------------- model ----------------
  logic [15:0] m_x [2], m_y [2], m_z [2];
  logic [5:0]  m_c [2];
  logic [31:0] m_vn [2], m_er [2];
  logic [19:0] m_fe [2], m_addr [2];
  snap_t qa[$], qb[$];

  task automatic mreset(input int w);
    m_x[w] = '0; m_y[w] = '0; m_z[w] = '0; m_c[w] = '0;
    m_vn[w] = '0; m_er[w] = '0; m_fe[w] = '0; m_addr[w] = '0;
  endtask

  function automatic snap_t snap(input int w, input bit b, input bit d, input bit p);
    snap_t s;
    s.busy = b; s.done = d; s.pulse = p; s.addr = m_addr[w];
    s.vnum = m_vn[w]; s.errs = m_er[w]; s.ferr = m_fe[w];
    s.x = m_x[w]; s.y = m_y[w]; s.z = m_z[w]; s.ctl = m_c[w];
    return s;
  endfunction

  task automatic push(input int w, input snap_t s);
    if (w == 0) qa.push_back(s);
    else qb.push_back(s);
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? qa.size() : qb.size();
  endfunction

  // Expands one run into per-cycle snapshots. Each vector gives a FETCH, an
  // APPLY and a CHECK snapshot. The run ends on an invalid vector, on the last
  // address, or when the error limit is reached. Three DONE snapshots follow.
  task automatic build(input int w, input int aw, input int maxe);
    logic [19:0] last;
    logic [19:0] fr;
    bit pulse, mm;
    int a;
    last = 20'((1 << aw) - 1);
    m_vn[w] = '0; m_er[w] = '0; m_fe[w] = '0;
    pulse = 1'b0;
    a = 0;
    while (1) begin
      m_addr[w] = 20'(a);
      push(w, snap(w, 1, 0, pulse));
      pulse = 1'b0;
      push(w, snap(w, 1, 0, 0));
      if (!vld[w][a]) break;
      m_x[w] = mem[w][a][75:60];
      m_y[w] = mem[w][a][59:44];
      m_z[w] = mem[w][a][43:28];
      m_c[w] = mem[w][a][25:20];
      push(w, snap(w, 1, 0, 0));
      fr = fake_fma(m_x[w], m_y[w], m_z[w], m_c[w]);
      mm = (fr[15:0] != mem[w][a][19:4]);
`ifdef FMA16_FLAG_CHECK_EN
      mm = mm || (fr[19:16] != mem[w][a][3:0]);
`endif
      if (mm) begin
        if (m_er[w] == 0) m_fe[w] = 20'(a);
        if (m_er[w] != 32'hFFFF_FFFF) m_er[w] = m_er[w] + 1;
      end
      if (m_vn[w] != 32'hFFFF_FFFF) m_vn[w] = m_vn[w] + 1;
      pulse = mm;
      if (20'(a) == last || (maxe != 0 && m_er[w] == 32'(maxe))) break;
      a++;
    end
    push(w, snap(w, 0, 1, pulse));
    push(w, snap(w, 0, 1, 0));
    push(w, snap(w, 0, 1, 0));
  endtask

  // ---------------- compare processes ----------------
  snap_t act_a, act_b, ea, eb;
  assign act_a = {busy_a, done_a, err_pulse_a, vaddr_a, vectornum_a, errors_a, ferr_a,
                  x_a, y_a, z_a, rm_a, mul_a, add_a, negp_a, negz_a};
  assign act_b = {busy_b, done_b, err_pulse_b, 18'b0, vaddr_b, vectornum_b, errors_b,
                  18'b0, ferr_b, x_b, y_b, z_b, rm_b, mul_b, add_b, negp_b, negz_b};

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      n_checks++;
      if (act_a !== ea) begin
        n_errors++;
        $display("[TB] FAIL trace_a: got %h expected %h", act_a, ea);
      end
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      n_checks++;
      if (act_b !== eb) begin
        n_errors++;
        $display("[TB] FAIL trace_b: got %h expected %h", act_b, eb);
      end
    end
  end

  int pulse_cnt_a = 0;
  always @(negedge clk) if (err_pulse_a) pulse_cnt_a++;

  // ---------------- helpers ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem(input int w);
    for (int i = 0; i < 16; i++) begin
      mem[w][i] = '0;
      vld[w][i] = 1'b0;
    end
  endtask

  task automatic setvec(input int w, input int a, input logic [15:0] vx, input logic [15:0] vy,
                        input logic [15:0] vz, input logic [7:0] ctrl, input logic [15:0] rexp,
                        input logic [3:0] fexp);
    mem[w][a] = {vx, vy, vz, ctrl, rexp, fexp};
    vld[w][a] = 1'b1;
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v;
    else start_b = v;
  endtask

  // Starts a run, then waits until the DUT shows done and every expected
  // snapshot has been compared. cyc counts clock edges, starting with the
  // edge that samples start, up to the edge after which done is first seen.
  task automatic applyStimulus(input int w, output int cyc);
    int n;
    @(negedge clk); #1;
    if (w == 0) build(0, 20, 0);
    else build(1, 2, 2);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    n = 1;
    cyc = 0;
    for (int c = 0; c < 200; c++) begin
      if (cyc == 0 && ((w == 0) ? done_a : done_b)) cyc = n;
      if (cyc != 0 && qsize(w) == 0) break;
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (cyc == 0 || qsize(w) != 0) begin
      n_errors++;
      $display("[TB] FAIL run_timeout: edges %0d pending %0d", n, qsize(w));
      if (w == 0) qa.delete();
      else qb.delete();
    end
  endtask

  // ---------------- directed sequence ----------------
  int cyc;
  int p0;

  initial begin
    reset_a = 1'b0; reset_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    clear_mem(0); clear_mem(1);
    mreset(0); mreset(1);
    repeat (3) @(negedge clk);
    #1;
    reset_a = 1'b1; reset_b = 1'b1;

    checkOutput("rst_vec_addr", 32'(vaddr_a), 32'h0);
    checkOutput("rst_busy", 32'(busy_a), 32'h0);
    checkOutput("rst_done", 32'(done_a), 32'h0);
    checkOutput("rst_vectornum", vectornum_a, 32'h0);
    checkOutput("rst_x", 32'(x_a), 32'h0);

    // A single correct vector, then the end marker.
    clear_mem(0);
    setvec(0, 0, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'h0);
    applyStimulus(0, cyc);
    checkOutput("basic_latency", 32'(cyc), 32'd6);
    checkOutput("basic_vectornum", vectornum_a, 32'd1);
    checkOutput("basic_errors", errors_a, 32'd0);
    checkOutput("basic_done", 32'(done_a), 32'd1);

    // Expected 4000, the fma16 returns 3C00.
    clear_mem(0);
    setvec(0, 0, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h4000, 4'h0);
    p0 = pulse_cnt_a;
    applyStimulus(0, cyc);
    checkOutput("mis_errors", errors_a, 32'd1);
    checkOutput("mis_first_err", 32'(ferr_a), 32'd0);
    checkOutput("mis_pulses", 32'(pulse_cnt_a - p0), 32'd1);

    // The result matches but the flags differ (inexact set, 0 expected).
    clear_mem(0);
    setvec(0, 0, 16'h3C01, 16'h3C01, 16'h0000, 8'h08, 16'h3C02, 4'h0);
    applyStimulus(0, cyc);
`ifdef FMA16_FLAG_CHECK_EN
    checkOutput("flag_errors", errors_a, 32'd1);
`else
    checkOutput("flag_errors", errors_a, 32'd0);
`endif

    // A mixed run: ignored ctrl[7:6], roundmode, fused add, and mismatches at 2 and 4.
    clear_mem(0);
    setvec(0, 0, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'h0);
    setvec(0, 1, 16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
    setvec(0, 2, 16'h4000, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
    setvec(0, 3, 16'h3C01, 16'h3C01, 16'h0000, 8'h08, 16'h3C02, 4'h0);
    setvec(0, 4, 16'h3C00, 16'h3C00, 16'h3C00, 8'h0C, 16'h3C00, 4'h0);
    setvec(0, 5, 16'h1234, 16'h5678, 16'h9ABC, 8'hF8, 16'hDEC8, 4'h0);
    applyStimulus(0, cyc);
    checkOutput("mix_vectornum", vectornum_a, 32'd6);
`ifdef FMA16_FLAG_CHECK_EN
    checkOutput("mix_errors", errors_a, 32'd3);
`else
    checkOutput("mix_errors", errors_a, 32'd2);
`endif
    checkOutput("mix_first_err", 32'(ferr_a), 32'd2);
    checkOutput("mix_vec_addr", 32'(vaddr_a), 32'd6);

    // Reset during CHECK of vector 5. A start pulse during APPLY of vector 2 is ignored.
    setvec(0, 6, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'h0);
    setvec(0, 7, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'h0);
    @(negedge clk); #1;
    build(0, 20, 0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    qa.delete();
    mreset(0);
    repeat (3) qa.push_back('0);
    reset_a = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy_a), 32'h0);
    checkOutput("midrst_vectornum", vectornum_a, 32'h0);
    checkOutput("midrst_vec_addr", 32'(vaddr_a), 32'h0);
    checkOutput("midrst_x", 32'(x_a), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    reset_a = 1'b1;
    clear_mem(0);
    setvec(0, 0, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'h0);
    applyStimulus(0, cyc);
    checkOutput("restart_vectornum", vectornum_a, 32'd1);

    // Instance B: address space exhausted after address 3.
    setvec(1, 0, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'h0);
    setvec(1, 1, 16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0);
    setvec(1, 2, 16'h4000, 16'h4000, 16'h0000, 8'h08, 16'h4400, 4'h0);
    setvec(1, 3, 16'h3C00, 16'h3C00, 16'h3C00, 8'h0C, 16'h4000, 4'h0);
    applyStimulus(1, cyc);
    checkOutput("wrap_latency", 32'(cyc), 32'd13);
    checkOutput("wrap_vec_addr", 32'(vaddr_b), 32'd3);
    checkOutput("wrap_vectornum", vectornum_b, 32'd4);
    checkOutput("wrap_errors", errors_b, 32'd0);

    // Instance B: every vector mismatches, so the run stops at two errors.
    for (int i = 0; i < 4; i++)
      setvec(1, i, 16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h4000, 4'h0);
    applyStimulus(1, cyc);
    checkOutput("limit_latency", 32'(cyc), 32'd7);
    checkOutput("limit_vectornum", vectornum_b, 32'd2);
    checkOutput("limit_errors", errors_b, 32'd2);
    checkOutput("limit_first_err", 32'(ferr_b), 32'd0);
    checkOutput("limit_vec_addr", 32'(vaddr_b), 32'd1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
